// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: bytes written by the core are queued in a
// power-of-two FIFO and drained onto the serial line back to back.
module uart_tx_buffered #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DEPTH_LOG2   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dataWriteEnable,
    input  logic [7:0] dataWrite,
    output logic       dataWriteAck,
    output logic       dataWriteFull,
    output logic       txBusy,
    output logic       tx
);

    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [BAUD_W-1:0]     BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0]     BAUD_ONE   = BAUD_W'(1);
    localparam logic [DEPTH_LOG2:0]   COUNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   COUNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic [BAUD_W-1:0]     baud_q, baud_d;
    logic [2:0]            bit_q, bit_d;
    logic [7:0]            shift_q, shift_d;
    logic                  tx_q, tx_d;
    logic                  ack_q, full_q, busy_q;
    logic                  push, pop, baud_done;

    // Write strobe: dataWriteEnable is a single-cycle request with no stall;
    // it is accepted iff the FIFO was not full before the edge, otherwise the
    // byte is dropped. dataWriteAck reports the outcome one cycle later.
    assign push      = dataWriteEnable && (count_q < COUNT_FULL);
    assign baud_done = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when more data waits.
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        bit_d   = '0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + COUNT_ONE;
            2'b01:   count_d = count_q - COUNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            ack_q    <= 1'b0;
            full_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            ack_q    <= push;
            full_q   <= (count_d == COUNT_FULL);
            busy_q   <= (state_d != IDLE) || (count_d != '0);
        end
    end

    // Storage carries no reset; only slots behind the write pointer are read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= dataWrite;
        end
    end

    assign dataWriteAck  = ack_q;
    assign dataWriteFull = full_q;
    assign txBusy        = busy_q;
    assign tx            = tx_q;

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
Transmit-direction UART block. Accepts bytes from the core over a single-cycle write strobe and queues them in an internal power-of-two FIFO. Serializes them onto the tx line as 8N1 frames at a fixed clocks-per-bit rate. It is the outbound counterpart to the receive-side ring buffer: the core pushes bytes here, and this block drains them to the wire.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit; legal range is 2 or more.
DEPTH_LOG2, 4, FIFO holds exactly 2^DEPTH_LOG2 bytes; legal range is 1 to 8.

Ports:
clk  input  1  global clock; all state changes on its rising edge.
reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
dataWriteEnable  input  1  request to enqueue dataWrite this cycle.
dataWrite  input  8  byte to enqueue.
dataWriteAck  output  1  registered; 1 on the cycle after an accepted write, 0 on the cycle after a dropped write or no write.
dataWriteFull  output  1  registered; FIFO count equals 2^DEPTH_LOG2.
txBusy  output  1  registered; 1 while the FIFO is non-empty or a frame is in progress.
tx  output  1  registered serial line; idles high.

Behaviour:
- Reset (synchronous; takes effect at the edge where reset=1):
  - tx=1, dataWriteAck=0, dataWriteFull=0, txBusy=0.
  - FIFO read/write pointers and count=0; FSM=IDLE; bit counter=0, baud counter=0.
  - Reset mid-frame aborts the frame immediately and discards all queued bytes. No partial frame is completed.
- FIFO:
  - Circular buffer of 2^DEPTH_LOG2 bytes.
  - Pointers are DEPTH_LOG2 bits wide and wrap naturally; count is DEPTH_LOG2+1 bits.
  - Full and empty are decided by count only, never by pointer equality.
  - A write is accepted when dataWriteEnable=1 and count < depth, both sampled before this edge. A pop in the same cycle does not free space for that write (no bypass).
  - Writes while full are dropped silently; the FIFO is unchanged.
  - Simultaneous accepted write and pop leaves count unchanged; both pointers advance.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If count>0, pop the head into an 8-bit shift register, clear the baud counter, and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0], LSB first. Every CLKS_PER_BIT cycles, shift right and increment the bit index. After bit 7 completes, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At its final cycle:
    - if count>0, pop and go directly to START, with no idle gap between frames;
    - otherwise go to IDLE.
- Timing:
  - A frame is exactly 10*CLKS_PER_BIT cycles.
  - A write accepted at edge N into an empty, idle block is popped at edge N+1. tx first drives 0 after edge N+1.
  - dataWriteAck is a one-cycle pulse per accepted write. Consecutive accepted writes give consecutive 1s.
- txBusy=0 only when the FSM is IDLE and count=0. It drops on the edge at which the final STOP ends with an empty FIFO.
- No output is combinational from inputs.

Test Plan (CLKS_PER_BIT=4, DEPTH_LOG2=2):
1. Reset held for 2 cycles, then released with no writes -> tx=1, txBusy=0, dataWriteAck=0, dataWriteFull=0 for 20 cycles.
2. Single write of 0xA5 at edge 0:
   - dataWriteAck=1 for 1 cycle; tx goes low after edge 1.
   - tx bit sequence, each bit 4 cycles: 0,1,0,1,0,0,1,0,1,1 (40 cycles).
   - txBusy falls at edge 41.
3. Writes of 0x01 and 0x80 on consecutive cycles -> two frames with no high-idle gap between the 0x01 stop bit and the 0x80 start bit. Total busy time is 80 cycles.
4. Six consecutive writes 0x10..0x15 from idle:
   - Acks are 1,1,1,1,1,0; dataWriteFull=1 after the 5th write.
   - Wire carries exactly 0x10,0x11,0x12,0x13,0x14; 0x15 is never transmitted.
5. Full FIFO with a write on the same cycle that STOP pops -> write is dropped (ack=0); count goes from 4 to 3; the dropped byte never appears on tx.
6. Queue 0x3C and 0x55, then assert reset during DATA bit 3 of 0x3C:
   - Next edge: tx=1, txBusy=0, dataWriteFull=0.
   - A subsequent write of 0x7E transmits a clean frame; 0x55 is never sent.
